mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//  Parametrised MEM-stage bridge between the pipeline's load/store request and N_DEV memory-mapped devices (device 0 = DM).
//  Decodes address windows, checks access legality, raises AdEL(4)/AdES(5)/DBE(7), and drives a req/ready handshake.
//  Holds the pipeline on stall while a device is slow. Adds a per-device width policy, read-only words and a timeout.
// PARAMETERS
//  N_DEV       6                       number of device windows; device 0 is DM
//  DEV_BASE    {N_DEV x 32b}           packed base addresses; slot i is at [32*i+:32]
//  DEV_LIMIT   {N_DEV x 32b}           packed inclusive limit addresses
//  WORD_ONLY   N_DEV'b111110           bit i=1: device i accepts word accesses only
//  RO_EN       N_DEV'b000010           bit i=1: device i has one read-only word
//  RO_OFF      {N_DEV x 4b}            byte offset of that read-only word (timer: 4'h8)
//  TIMEOUT     15                      max ACCESS cycles before bus error; counter width is $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  flush       in   1         MEM-stage flush (exception/eret in flight)
//  req_valid   in   1         load or store present in MEM
//  req_we      in   1         1 = store, 0 = load
//  req_size    in   2         0 byte, 1 half, 2 word (3 is illegal -> AdEL/AdES)
//  req_be      in   4         byte enables, already lane-aligned
//  req_addr    in   32        effective address
//  req_wdata   in   32        lane-aligned store data
//  ovf_in      in   1         address-calculation overflow from EX
//  exc_in      in   5         exception code from earlier stages
//  dev_rdata   in   32*N_DEV  per-device read data
//  dev_ready   in   N_DEV     per-device completion strobe
//  dev_sel     out  N_DEV     one-hot device select; valid while dev_req is high
//  dev_req     out  1         access strobe
//  dev_we      out  1         write strobe, qualified by dev_req
//  dev_be      out  4         registered byte enables
//  dev_addr    out  32        registered address
//  dev_wdata   out  32        registered write data
//  stall       out  1         freezes IF..MEM
//  rdata       out  32        raw word from the selected device, for dmext
//  exc_out     out  5         exception code passed to WB/CP0
// BEHAVIOUR
//  Reset: state IDLE; timeout counter 0; all outputs 0.
//  Legality (combinational, IDLE only); the first match wins:
//   exc_in!=0 -> pass it through; no access
//   ovf_in | no window hit | req_size==3 -> 4 (load) or 5 (store)
//   misaligned (word: addr[1:0]!=0; half: addr[0]!=0) -> 4/5
//   WORD_ONLY device with size!=2 -> 4/5
//   store with RO_EN[i] and addr[3:0]==RO_OFF[i] -> 5
//   A failing request updates exc_out in the same cycle; stall stays 0 and no dev_req is issued.
//   When two windows overlap, the lowest index wins.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE: a legal req_valid with flush=0 registers sel, addr, be, wdata and we; stall=1 that cycle; go to ACCESS.
//   ACCESS: dev_req=1 and stall=1; the counter increments.
//    dev_ready[sel] -> latch rdata from that device's slot; go to DONE.
//    counter==TIMEOUT -> exc_out=7 registered into DONE; go to DONE.
//   DONE: stall=0 for exactly 1 cycle; rdata/exc_out valid; go to IDLE; counter cleared.
//  Minimum latency: 2 stall cycles (ready on the first ACCESS cycle). The pipeline holds req_* stable while stall=1.
//  Flush in ACCESS:
//   load: abort to IDLE next cycle; dev_req drops; rdata is not updated.
//   store: already committed; it completes normally.
//  Flush in IDLE/DONE: no new access is started.
//  dev_ready for a device other than sel is ignored. dev_ready held high from before ACCESS is accepted on cycle 1.
//  Reset asserted mid-ACCESS: IDLE immediately; dev_req/stall drop asynchronously.
// STRUCTURE
//  Package mem_bus_pkg: EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7; size encodings; state enum {IDLE,ACCESS,DONE}.
//  Sub-module mem_bus_decode: combinational window hit, one-hot sel and the legality/exception priority chain.
//  Top level: FSM, timeout counter, request registers, rdata mux.
// TESTING
//  lw 0x0000_1004 on DM, ready in the first ACCESS cycle -> stall high 2 cycles; rdata=mem word; exc_out=0.
//  sh to 0x0000_7F34 (LED, WORD_ONLY) -> exc_out=5 the same cycle; no dev_req; stall=0.
//  sw to 0x0000_7F08 (timer RO word) -> exc_out=5. sw to 0x0000_7F04 -> completes, dev_we=1.
//  lw 0x0000_7F10 with dev_ready never asserted -> 15 ACCESS cycles then DONE with exc_out=7.
//  lw in flight, flush in ACCESS cycle 2 -> IDLE next cycle; rdata unchanged.
//   Same case for sw -> the write still completes.
//  exc_in=10 with ovf_in=1 -> exc_out=10. Reset low mid-ACCESS -> stall=0 and dev_req=0 immediately.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared exception codes, size encodings and bridge FSM states
package mem_bus_pkg;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_bus_decode.sv
// mem_bus_decode: address window hit, one-hot select and exception priority chain
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int                   N_DEV     = 6,
    parameter logic [32*N_DEV-1:0]  DEV_BASE  = '0,
    parameter logic [32*N_DEV-1:0]  DEV_LIMIT = '0,
    parameter logic [N_DEV-1:0]     WORD_ONLY = '0,
    parameter logic [N_DEV-1:0]     RO_EN     = '0,
    parameter logic [4*N_DEV-1:0]   RO_OFF    = '0
) (
    input  logic             valid,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic [31:0]      addr,
    input  logic             ovf,
    input  logic [4:0]       exc_in,
    output logic [N_DEV-1:0] sel,
    output logic             legal,
    output logic [4:0]       exc
);
    logic hit, word_only, ro_hit, misaligned, bad;

    // scan from the top so the lowest matching window overwrites the rest
    always_comb begin
        sel       = '0;
        hit       = 1'b0;
        word_only = 1'b0;
        ro_hit    = 1'b0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (addr >= DEV_BASE[32*i+:32] && addr <= DEV_LIMIT[32*i+:32]) begin
                sel       = '0;
                sel[i]    = 1'b1;
                hit       = 1'b1;
                word_only = WORD_ONLY[i];
                ro_hit    = RO_EN[i] && addr[3:0] == RO_OFF[4*i+:4];
            end
        end
    end

    assign misaligned = size == SIZE_WORD ? |addr[1:0] : size == SIZE_HALF && addr[0];
    assign bad        = ovf || !hit || size == SIZE_BAD || misaligned || (word_only && size != SIZE_WORD);
    assign exc        = exc_in != '0 ? exc_in :
                        !valid       ? '0 :
                        bad          ? (we ? EXC_ADES : EXC_ADEL) :
                        we && ro_hit ? EXC_ADES : '0;
    assign legal      = valid && exc == '0;
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: MEM-stage load/store bridge to memory-mapped devices with handshake and timeout
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int                   N_DEV     = 6,
    parameter logic [32*N_DEV-1:0]  DEV_BASE  = {32'h0000_7F38, 32'h0000_7F34, 32'h0000_7F2C,
                                                 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000},
    parameter logic [32*N_DEV-1:0]  DEV_LIMIT = {32'h0000_7F3F, 32'h0000_7F37, 32'h0000_7F33,
                                                 32'h0000_7F2B, 32'h0000_7F0B, 32'h0000_2FFF},
    parameter logic [N_DEV-1:0]     WORD_ONLY = 6'b111110,
    parameter logic [N_DEV-1:0]     RO_EN     = 6'b000010,
    parameter logic [4*N_DEV-1:0]   RO_OFF    = {4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0},
    parameter int                   TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic [3:0]         req_be,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic               ovf_in,
    input  logic [4:0]         exc_in,
    input  logic [32*N_DEV-1:0] dev_rdata,
    input  logic [N_DEV-1:0]   dev_ready,
    output logic [N_DEV-1:0]   dev_sel,
    output logic               dev_req,
    output logic               dev_we,
    output logic [3:0]         dev_be,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    output logic               stall,
    output logic [31:0]        rdata,
    output logic [4:0]         exc_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, nxt;
    logic [N_DEV-1:0]  dec_sel, sel_q;
    logic              dec_legal, we_q, start, ready_hit, abort, timed_out;
    logic [4:0]        dec_exc, exc_q;
    logic [CW-1:0]     cnt;
    logic [31:0]       rdata_q, rdata_mux;

    mem_bus_decode #(
        .N_DEV(N_DEV), .DEV_BASE(DEV_BASE), .DEV_LIMIT(DEV_LIMIT),
        .WORD_ONLY(WORD_ONLY), .RO_EN(RO_EN), .RO_OFF(RO_OFF)
    ) u_decode (
        .valid(req_valid), .we(req_we), .size(req_size), .addr(req_addr),
        .ovf(ovf_in), .exc_in(exc_in), .sel(dec_sel), .legal(dec_legal), .exc(dec_exc)
    );

    // reset is folded in so the IDLE-cycle stall and exception drop while reset is held
    assign start     = reset && state == IDLE && dec_legal && !flush;
    assign ready_hit = |(dev_ready & sel_q);
    assign abort     = flush && !we_q;
    assign timed_out = cnt + CW'(1) == CW'(TIMEOUT);

    // pick the selected device's read word
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_DEV; i++)
            rdata_mux = rdata_mux | (sel_q[i] ? dev_rdata[32*i+:32] : 32'h0);
    end

    // next state: a flushed load is dropped, a store always runs to completion
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ACCESS : IDLE;
            ACCESS:  nxt = abort ? IDLE : (ready_hit || timed_out) ? DONE : ACCESS;
            default: nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // request capture, ACCESS cycle counter, read data and bus-error latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q     <= '0;
            we_q      <= 1'b0;
            dev_be    <= '0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            exc_q     <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            if (start) begin
                sel_q     <= dec_sel;
                we_q      <= req_we;
                dev_be    <= req_be;
                dev_addr  <= req_addr;
                dev_wdata <= req_wdata;
                exc_q     <= '0;
            end
            cnt <= (state == ACCESS && nxt == ACCESS) ? cnt + CW'(1) : '0;
            if (state == ACCESS && !abort) begin
                if (ready_hit)      rdata_q <= rdata_mux;
                else if (timed_out) exc_q   <= EXC_DBE;
            end
        end
    end

    assign dev_sel = sel_q;
    assign dev_req = state == ACCESS;
    assign dev_we  = dev_req && we_q;
    assign stall   = dev_req || start;
    assign rdata   = rdata_q;
    assign exc_out = state == DONE ? exc_q : (state == IDLE && reset) ? dec_exc : '0;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed checks of decode, handshake, timeout, flush and reset behaviour
module tb_mem_bus_bridge;
    logic         clk = 1'b0;
    logic         reset, flush, req_valid, req_we, ovf_in;
    logic [1:0]   req_size;
    logic [3:0]   req_be;
    logic [31:0]  req_addr, req_wdata;
    logic [4:0]   exc_in;
    logic [191:0] dev_rdata;
    logic [5:0]   dev_ready;
    logic [5:0]   dev_sel;
    logic         dev_req, dev_we, stall;
    logic [3:0]   dev_be;
    logic [31:0]  dev_addr, dev_wdata, rdata;
    logic [4:0]   exc_out;
    int           n_chk = 0;
    int           n_pass = 0;
    int           n;

    assign dev_rdata = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
                        32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    always #5 clk = ~clk;

    mem_bus_bridge dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .ovf_in(ovf_in), .exc_in(exc_in), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
        .dev_sel(dev_sel), .dev_req(dev_req), .dev_we(dev_we), .dev_be(dev_be),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .stall(stall), .rdata(rdata), .exc_out(exc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic req(input logic w, input logic [1:0] s, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = w;
        req_size  = s;
        req_be    = b;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; ovf_in = 1'b0;
        req_size = 2'd0; req_be = 4'h0; req_addr = '0; req_wdata = '0; exc_in = '0; dev_ready = '0;
        @(negedge clk); #1;
        check("rst_stall", stall, 0);
        check("rst_req", dev_req, 0);
        check("rst_exc", exc_out, 0);
        check("rst_rdata", rdata, 0);
        check("rst_sel", dev_sel, 0);
        reset = 1'b1;

        // lw on DM with ready already high
        @(negedge clk); req(0, 2, 4'hf, 32'h0000_1004, 0); dev_ready = 6'b000001; #1;
        check("lw_idle_stall", stall, 1);
        check("lw_idle_req", dev_req, 0);
        @(negedge clk); #1;
        check("lw_acc_stall", stall, 1);
        check("lw_acc_req", dev_req, 1);
        check("lw_acc_sel", dev_sel, 6'b000001);
        check("lw_acc_addr", dev_addr, 32'h0000_1004);
        check("lw_acc_we", dev_we, 0);
        @(negedge clk); #1;
        check("lw_done_stall", stall, 0);
        check("lw_done_rdata", rdata, 32'h1111_1111);
        check("lw_done_exc", exc_out, 0);
        req_valid = 1'b0; dev_ready = '0;

        // sh to word-only LED
        @(negedge clk); req(1, 1, 4'b0011, 32'h0000_7F34, 0); #1;
        check("led_exc", exc_out, 5);
        check("led_stall", stall, 0);
        check("led_req", dev_req, 0);
        @(negedge clk); #1;
        check("led_noreq", dev_req, 0);

        // sw to the timer read-only word
        req(1, 2, 4'hf, 32'h0000_7F08, 0); #1;
        check("ro_exc", exc_out, 5);
        check("ro_stall", stall, 0);

        // sw to a writable timer word, wrong-device ready ignored
        @(negedge clk); req(1, 2, 4'hf, 32'h0000_7F04, 32'hDEAD_BEEF); #1;
        check("sw_idle_stall", stall, 1);
        @(negedge clk); #1;
        check("sw_acc_req", dev_req, 1);
        check("sw_acc_we", dev_we, 1);
        check("sw_acc_sel", dev_sel, 6'b000010);
        check("sw_acc_wdata", dev_wdata, 32'hDEAD_BEEF);
        check("sw_acc_be", dev_be, 4'hf);
        dev_ready = 6'b000001;
        @(negedge clk); #1;
        check("sw_wrong_rdy", dev_req, 1);
        dev_ready = 6'b000010;
        @(negedge clk); #1;
        check("sw_done_stall", stall, 0);
        check("sw_done_exc", exc_out, 0);
        req_valid = 1'b0; dev_ready = '0;

        // lw that never gets ready -> timeout
        @(negedge clk); req(0, 2, 4'hf, 32'h0000_7F10, 0); #1;
        check("tmo_idle_stall", stall, 1);
        @(negedge clk); #1;
        n = 0;
        while (dev_req && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        check("tmo_cycles", n, 15);
        check("tmo_exc", exc_out, 7);
        check("tmo_stall", stall, 0);
        check("tmo_rdata", rdata, 32'h2222_2222);
        req_valid = 1'b0;

        // lw flushed in ACCESS cycle 2, ready in the same cycle ignored
        @(negedge clk); req(0, 2, 4'hf, 32'h0000_1008, 0); #1;
        @(negedge clk); #1;
        check("lwf_c1_req", dev_req, 1);
        @(negedge clk); flush = 1'b1; dev_ready = 6'b000001; #1;
        check("lwf_c2_req", dev_req, 1);
        @(negedge clk); flush = 1'b0; req_valid = 1'b0; dev_ready = '0; #1;
        check("lwf_req", dev_req, 0);
        check("lwf_stall", stall, 0);
        check("lwf_rdata", rdata, 32'h2222_2222);
        check("lwf_exc", exc_out, 0);

        // sw flushed in ACCESS cycle 2 still completes
        @(negedge clk); req(1, 2, 4'hf, 32'h0000_1010, 32'hCAFE_F00D); #1;
        @(negedge clk); #1;
        @(negedge clk); flush = 1'b1; #1;
        check("swf_c2_we", dev_we, 1);
        @(negedge clk); flush = 1'b0; dev_ready = 6'b000001; #1;
        check("swf_still", dev_req, 1);
        @(negedge clk); #1;
        check("swf_done_stall", stall, 0);
        check("swf_done_exc", exc_out, 0);
        req_valid = 1'b0; dev_ready = '0;

        // exception priority chain, all within IDLE
        @(negedge clk); exc_in = 5'd10; ovf_in = 1'b1; req(0, 2, 4'hf, 32'h0000_1000, 0); #1;
        check("excin_exc", exc_out, 10);
        check("excin_stall", stall, 0);
        exc_in = '0; #1;
        check("ovf_ld_exc", exc_out, 4);
        req_we = 1'b1; #1;
        check("ovf_st_exc", exc_out, 5);
        @(negedge clk); ovf_in = 1'b0; req(0, 2, 4'hf, 32'h0000_1002, 0); #1;
        check("mis_exc", exc_out, 4);
        req_addr = 32'h9000_0000; #1;
        check("nohit_exc", exc_out, 4);
        req_addr = 32'h0000_1000; req_size = 2'd3; #1;
        check("size3_exc", exc_out, 4);

        // flush in IDLE blocks a legal access
        @(negedge clk); flush = 1'b1; req(0, 2, 4'hf, 32'h0000_1000, 0); #1;
        check("fidle_stall", stall, 0);
        check("fidle_exc", exc_out, 0);
        @(negedge clk); #1;
        check("fidle_req", dev_req, 0);

        // reset asserted mid-ACCESS
        flush = 1'b0; req(0, 2, 4'hf, 32'h0000_1004, 0);
        @(negedge clk); #1;
        check("rmid_req_before", dev_req, 1);
        #1 reset = 1'b0;
        #1;
        check("rmid_stall", stall, 0);
        check("rmid_req", dev_req, 0);
        check("rmid_sel", dev_sel, 0);
        check("rmid_rdata", rdata, 0);
        @(negedge clk); req_valid = 1'b0; reset = 1'b1; #1;
        check("rmid_after", stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
